// File: rtl/mmio_pkg.sv
// Shared MMIO constants for the read-response path.
package mmio_pkg;

   localparam int unsigned MMIO_TID_WIDTH  = 9;
   localparam int unsigned MMIO_DATA_WIDTH = 64;
   localparam logic [MMIO_DATA_WIDTH-1:0] TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

   // Saturating 16-bit increment for event counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/mmio_rd_resp_queue_tid_fifo.sv
// Register-based show-ahead FIFO holding outstanding MMIO read TIDs.
module tid_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 9
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               head,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mmio_rd_resp_queue.sv
// Orders MMIO read responses against their request TIDs; optional head-of-queue
// timeout with synthetic responses is enabled by defining MMIO_RD_TIMEOUT_EN.
module mmio_rd_resp_queue
   import mmio_pkg::*;
#(
   parameter int unsigned DEPTH          = 8,
   parameter int unsigned DATA_WIDTH     = MMIO_DATA_WIDTH,
   parameter int unsigned TID_WIDTH      = MMIO_TID_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   input  logic [TID_WIDTH-1:0]           req_tid,
   input  logic                           rd_data_valid,
   input  logic [DATA_WIDTH-1:0]          rd_data,
   output logic                           rsp_valid,
   output logic [TID_WIDTH-1:0]           rsp_tid,
   output logic [DATA_WIDTH-1:0]          rsp_data,
   output logic [$clog2(DEPTH+1)-1:0]     outstanding,
   output logic                           overflow,
   output logic                           underflow,
   output logic [15:0]                    timeout_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2)
   begin : g_cfg_err
      $error("mmio_rd_resp_queue: unsupported DEPTH or TIMEOUT_CYCLES");
   end

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [TID_WIDTH-1:0] head_tid;
   logic                 absorb_c;
   logic                 data_pop_c;
   logic                 timeout_pop_c;
   logic                 pop_c;
   logic                 push_c;

   tid_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TID_WIDTH)
   ) u_tid_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_c),
      .push_data (req_tid),
      .pop       (pop_c),
      .head      (head_tid),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outstanding)
   );

   // Data owed to an already timed-out read is absorbed before it can pop the queue.
   assign data_pop_c = rd_data_valid && !absorb_c && !fifo_empty;
   assign pop_c      = data_pop_c || timeout_pop_c;
   assign push_c     = req_valid && (!fifo_full || pop_c);

`ifdef MMIO_RD_TIMEOUT_EN
   localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES);

   logic [AGE_W-1:0] age;
   logic [CNT_W-1:0] drop_pending;

   assign absorb_c      = rd_data_valid && (drop_pending != '0);
   assign timeout_pop_c = !fifo_empty && !data_pop_c &&
                          (age == AGE_W'(TIMEOUT_CYCLES - 1));

   // Head age, owed-data tracking and timeout statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         age           <= '0;
         drop_pending  <= '0;
         timeout_count <= '0;
      end else begin
         if (fifo_empty || pop_c) age <= '0;
         else                     age <= age + AGE_W'(1);

         if (timeout_pop_c && !absorb_c) begin
            if (drop_pending != CNT_W'(DEPTH)) drop_pending <= drop_pending + CNT_W'(1);
         end else if (absorb_c && !timeout_pop_c) begin
            drop_pending <= drop_pending - CNT_W'(1);
         end

         if (timeout_pop_c) timeout_count <= sat_inc16(timeout_count);
      end
   end
`else
   assign absorb_c      = 1'b0;
   assign timeout_pop_c = 1'b0;
   assign timeout_count = '0;
`endif

   // Registered response and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_tid   <= '0;
         rsp_data  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         rsp_valid <= pop_c;
         if (pop_c) begin
            rsp_tid  <= head_tid;
            rsp_data <= timeout_pop_c ? DATA_WIDTH'(TIMEOUT_DATA) : rd_data;
         end
         if (req_valid && fifo_full && !pop_c)           overflow  <= 1'b1;
         if (rd_data_valid && !absorb_c && fifo_empty)   underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mmio_rd_resp_queue.sv
// Directed self-checking bench for mmio_rd_resp_queue (DEPTH=8, TIMEOUT_CYCLES=16).
module tb_mmio_rd_resp_queue;

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned DW      = 64;
   localparam int unsigned TW      = 9;
   localparam int unsigned TO      = 16;
   localparam logic [63:0] TO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [TW-1:0] req_tid;
   logic          rd_data_valid;
   logic [DW-1:0] rd_data;
   logic          rsp_valid;
   logic [TW-1:0] rsp_tid;
   logic [DW-1:0] rsp_data;
   logic [3:0]    outstanding;
   logic          overflow;
   logic          underflow;
   logic [15:0]   timeout_count;

   int n_total  = 0;
   int n_passed = 0;

   mmio_rd_resp_queue #(
      .DEPTH          (DEPTH),
      .DATA_WIDTH     (DW),
      .TID_WIDTH      (TW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_tid       (req_tid),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .rsp_valid     (rsp_valid),
      .rsp_tid       (rsp_tid),
      .rsp_data      (rsp_data),
      .outstanding   (outstanding),
      .overflow      (overflow),
      .underflow     (underflow),
      .timeout_count (timeout_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else             n_passed++;
   endtask

   // Advance one clock; outputs are then sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; rd_data_valid = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic ret_data(input logic [63:0] d);
      rd_data_valid = 1'b1; rd_data = d;
      step();
      rd_data_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      req_tid = '0; rd_data = '0;
      do_reset();
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_flags", {61'd0, overflow, underflow, 1'b0}, 64'd0);
      chk("rst_timeout_count", 64'(timeout_count), 64'd0);

      // Single read with 3-cycle data latency.
      req_valid = 1'b1; req_tid = 9'h011;
      step();
      req_valid = 1'b0;
      chk("one_outstanding", 64'(outstanding), 64'd1);
      step(); step();
      ret_data(64'h1234);
      chk("one_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("one_rsp_tid", 64'(rsp_tid), 64'h011);
      chk("one_rsp_data", rsp_data, 64'h1234);
      chk("one_outstanding_0", 64'(outstanding), 64'd0);
      step();
      chk("one_pulse", 64'(rsp_valid), 64'd0);
      chk("one_tid_hold", 64'(rsp_tid), 64'h011);
      chk("one_data_hold", rsp_data, 64'h1234);

      // Data with nothing outstanding.
      ret_data(64'h77);
      chk("uf_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("uf_flag", 64'(underflow), 64'd1);

      // Push and pop together on an empty queue.
      do_reset();
      req_valid = 1'b1; req_tid = 9'h033;
      ret_data(64'h99);
      req_valid = 1'b0;
      chk("pp_empty_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("pp_empty_underflow", 64'(underflow), 64'd1);
      chk("pp_empty_outstanding", 64'(outstanding), 64'd1);

      // Fill, overflow, then drain in order.
      do_reset();
      req_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         req_tid = TW'(i);
         step();
      end
      chk("fill_outstanding", 64'(outstanding), 64'd8);
      chk("fill_no_overflow", 64'(overflow), 64'd0);
      req_tid = 9'd9;
      step();
      req_valid = 1'b0;
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_outstanding", 64'(outstanding), 64'd8);
      rd_data_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         rd_data = 64'hA000 + 64'(i);
         step();
         chk("drain_valid", 64'(rsp_valid), 64'd1);
         chk("drain_tid", 64'(rsp_tid), 64'(i));
         chk("drain_data", rsp_data, 64'hA000 + 64'(i));
      end
      rd_data_valid = 1'b0;
      chk("drain_outstanding", 64'(outstanding), 64'd0);
      chk("drain_no_underflow", 64'(underflow), 64'd0);

      // Full queue: simultaneous push and pop both accepted.
      do_reset();
      req_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         req_tid = TW'(9'h020 + 9'(i));
         step();
      end
      req_tid = 9'h0AA;
      ret_data(64'hBEEF);
      req_valid = 1'b0;
      chk("fullpp_outstanding", 64'(outstanding), 64'd8);
      chk("fullpp_overflow", 64'(overflow), 64'd0);
      chk("fullpp_rsp_tid", 64'(rsp_tid), 64'h021);
      chk("fullpp_rsp_data", rsp_data, 64'hBEEF);
      for (int k = 0; k < 8; k++) begin
         ret_data(64'h100 + 64'(k));
         chk("fullpp_drain_tid", 64'(rsp_tid), (k < 7) ? 64'h22 + 64'(k) : 64'h0AA);
      end
      chk("fullpp_outstanding_0", 64'(outstanding), 64'd0);

`ifdef MMIO_RD_TIMEOUT_EN
      // Head times out after TO cycles; late data is absorbed silently.
      do_reset();
      req_valid = 1'b1; req_tid = 9'd5;
      step();
      req_valid = 1'b0;
      repeat (TO - 1) step();
      chk("to_not_early", 64'(rsp_valid), 64'd0);
      step();
      chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("to_rsp_tid", 64'(rsp_tid), 64'd5);
      chk("to_rsp_data", rsp_data, TO_DATA);
      chk("to_count", 64'(timeout_count), 64'd1);
      chk("to_outstanding", 64'(outstanding), 64'd0);
      step();
      chk("to_pulse", 64'(rsp_valid), 64'd0);
      ret_data(64'h55);
      chk("late_no_rsp", 64'(rsp_valid), 64'd0);
      chk("late_no_underflow", 64'(underflow), 64'd0);
      ret_data(64'h56);
      chk("after_late_underflow", 64'(underflow), 64'd1);
`else
      // Without the timeout feature the head waits indefinitely.
      do_reset();
      req_valid = 1'b1; req_tid = 9'd5;
      step();
      req_valid = 1'b0;
      repeat (40) step();
      chk("wait_no_rsp", 64'(rsp_valid), 64'd0);
      chk("wait_outstanding", 64'(outstanding), 64'd1);
      chk("wait_timeout_count", 64'(timeout_count), 64'd0);
      ret_data(64'h66);
      chk("wait_rsp_tid", 64'(rsp_tid), 64'd5);
      chk("wait_rsp_data", rsp_data, 64'h66);
`endif

      // Reset mid-operation with 3 entries queued.
      do_reset();
      ret_data(64'h1);
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_tid = TW'(9'h040 + 9'(i));
         step();
      end
      req_valid = 1'b0;
      chk("pre_rst_outstanding", 64'(outstanding), 64'd3);
      chk("pre_rst_underflow", 64'(underflow), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_flags", {62'd0, overflow, underflow}, 64'd0);
      chk("mid_rst_timeout_count", 64'(timeout_count), 64'd0);
      step();
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      ret_data(64'h2);
      chk("post_rst_data_no_rsp", 64'(rsp_valid), 64'd0);
      chk("post_rst_underflow", 64'(underflow), 64'd1);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
